// File: rtl/uart_rx.sv
// UART receiver: start, DATA_LENGTH data bits LSB first, parity, stop; valid/ready output with per-word error flags.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority sampling of data, parity and stop bits.
module uart_rx #(
    parameter int DATA_LENGTH = 8,
    parameter int CLK_FREQ    = 1_600_000,
    parameter int BAUD_RATE   = 100_000,
    parameter bit PARITY_MODE = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_sig,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
    localparam int IDX_W            = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_LENGTH - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] VOTE0_AT  = CNT_W'(PULSE_WIDTH - 2);
    localparam logic [CNT_W-1:0] VOTE1_AT  = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(PULSE_WIDTH);
    // The third vote costs one extra clock; restarting at 1 keeps the bit period at PULSE_WIDTH.
    localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] SAMPLE_AT   = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(0);
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                 state_q;
    logic                   rx_meta_q;
    logic                   rx_s_q;
    logic [CNT_W-1:0]       clk_cnt_q;
    logic [IDX_W-1:0]       data_cnt_q;
    logic [DATA_LENGTH-1:0] shift_q;
    logic                   par_acc_q;
    logic                   par_err_q;
    logic [DATA_LENGTH-1:0] data_q;
    logic                   valid_q;
    logic                   parity_err_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   bit_done_d;
    logic                   bit_sample_d;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic vote0_q;
    logic vote1_q;

    always_comb begin
        bit_sample_d = (vote0_q & vote1_q) | (vote0_q & rx_s_q) | (vote1_q & rx_s_q);
    end
`else
    always_comb begin
        bit_sample_d = rx_s_q;
    end
`endif

    always_comb begin
        bit_done_d = (clk_cnt_q == SAMPLE_AT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            clk_cnt_q    <= '0;
            data_cnt_q   <= '0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            par_err_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            vote0_q      <= 1'b1;
            vote1_q      <= 1'b1;
`endif
        end else begin
            rx_meta_q <= rx_sig;
            rx_s_q    <= rx_meta_q;
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
`ifdef UART_RX_MAJORITY_VOTE_EN
            if (clk_cnt_q == VOTE0_AT) vote0_q <= rx_s_q;
            if (clk_cnt_q == VOTE1_AT) vote1_q <= rx_s_q;
`endif
            if (valid_q && ready) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rx_s_q) state_q <= S_START;
                end
                S_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            data_cnt_q <= '0;
                            par_acc_q  <= PARITY_MODE;
                            state_q    <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_done_d) begin
                        clk_cnt_q           <= CNT_RESTART;
                        shift_q[data_cnt_q] <= bit_sample_d;
                        par_acc_q           <= par_acc_q ^ bit_sample_d;
                        if (data_cnt_q == LAST_BIT) state_q <= S_PARITY;
                        else data_cnt_q <= data_cnt_q + IDX_W'(1);
                    end
                end
                S_PARITY: begin
                    if (bit_done_d) begin
                        clk_cnt_q <= CNT_RESTART;
                        par_err_q <= (bit_sample_d != par_acc_q);
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_done_d) begin
                        // A delivery overrides a same-cycle handshake.
                        clk_cnt_q    <= '0;
                        data_q       <= shift_q;
                        parity_err_q <= par_err_q;
                        frame_err_q  <= !bit_sample_d;
                        overrun_q    <= valid_q && !ready;
                        valid_q      <= 1'b1;
                        state_q      <= bit_sample_d ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    clk_cnt_q <= '0;
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
endmodule
